// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_pkg
//  Description : Shared types and constants for the modular-exponentiation
//                sequencer: FSM state encoding, default operand widths and
//                the accumulator start value.
//  Revision    : 1.0 - initial release
// ============================================================================
package modexp_pkg;

    localparam int DEFAULT_WIDTH     = 6;
    localparam int DEFAULT_EXP_WIDTH = 6;

    // Accumulator seed for left-to-right square-and-multiply.
    localparam int ACC_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_SQ_REQ   = 3'd2,
        ST_SQ_WAIT  = 3'd3,
        ST_MUL_REQ  = 3'd4,
        ST_MUL_WAIT = 3'd5,
        ST_NEXT     = 3'd6,
        ST_FINISH   = 3'd7
    } modexp_state_t;

endpackage
`default_nettype wire

// File: rtl/modexp_exp_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_exp_scanner
//  Description : Holds the captured exponent and walks a bit index from the
//                MSB down to bit 0, one position per step pulse.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk        in   clock, rising edge
//    reset_n    in   asynchronous active-low reset
//    load       in   capture exponent_in, index <= EXP_WIDTH-1
//    step       in   decrement the index
//    exponent_in in  exponent to capture
//    bit_value  out  exponent bit at the current index
//    last_bit   out  index is at bit 0
// ============================================================================
module modexp_exp_scanner
    import modexp_pkg::*;
#(
    parameter int EXP_WIDTH = DEFAULT_EXP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic                 step,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    output logic                 bit_value,
    output logic                 last_bit
);

    localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    logic [EXP_WIDTH-1:0] exp_q;
    logic [IDX_W-1:0]     idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            exp_q <= exponent_in;
            idx_q <= IDX_W'(EXP_WIDTH - 1);
        end else if (step) begin
            idx_q <= idx_q - 1'b1;
        end
    end

    assign bit_value = exp_q[idx_q];
    assign last_bit  = (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/modexp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : modexp_sequencer
//  Description : Computes base^exponent mod modulus by left-to-right
//                square-and-multiply, issuing one request per step to an
//                external modular multiplier and waiting for its answer.
//                Optional build macro MODEXP_TIMEOUT_EN adds a response
//                time limit of TIMEOUT_CYCLES in the wait states.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, reset_n           clock (rising edge), async active-low reset
//    start                  one-cycle request, sampled only when idle
//    base/exponent/modulus  operands captured on an accepted start
//    busy                   operation in progress
//    done                   one-cycle pulse, result/err valid
//    err                    modulus < 2 (or multiplier timeout)
//    result                 final value, held until overwritten
//    mul_start              one-cycle request to the multiplier
//    mul_a/mul_b/mul_n      multiplier operands, stable until answered
//    mul_ready/mul_answer   multiplier response (level valid, product mod n)
// ============================================================================
module modexp_sequencer
    import modexp_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int EXP_WIDTH      = DEFAULT_EXP_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_n,
    input  logic                 mul_ready,
    input  logic [WIDTH-1:0]     mul_answer
);

    modexp_state_t    state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] mul_n_q, mul_n_d;
    logic             wait_armed_q;
    logic             scan_load, scan_step;
    logic             scan_bit, scan_last;
    logic             answer_ok;
    logic             timeout_hit;

    modexp_exp_scanner #(
        .EXP_WIDTH (EXP_WIDTH)
    ) u_scanner (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (scan_load),
        .step        (scan_step),
        .exponent_in (exponent),
        .bit_value   (scan_bit),
        .last_bit    (scan_last)
    );

    // wait_armed_q is low in the first cycle of a wait state, so a ready
    // left over from the previous transaction is never taken as the answer.
    assign answer_ok = wait_armed_q && mul_ready;

`ifdef MODEXP_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic            in_wait;
    logic [TO_W-1:0] to_cnt_q;

    assign in_wait = (state_q == ST_SQ_WAIT) || (state_q == ST_MUL_WAIT);

    // Counts wait cycles since the last request; the limit is reached on the
    // TIMEOUT_CYCLES-th wait cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else if (mul_start) begin
            to_cnt_q <= '0;
        end else if (in_wait && (to_cnt_q != TO_W'(TIMEOUT_CYCLES - 1))) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = in_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Constant false: the wait states block until the multiplier answers.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        mod_d     = mod_q;
        acc_d     = acc_q;
        result_d  = result_q;
        err_d     = err_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_n_d   = mul_n_q;
        scan_load = 1'b0;
        scan_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d    = base;
                    mod_d     = modulus;
                    acc_d     = WIDTH'(ACC_ONE);
                    scan_load = 1'b1;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mod_q < WIDTH'(2)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_FINISH;
                end else begin
                    err_d   = 1'b0;
                    mul_a_d = acc_q;
                    mul_b_d = acc_q;
                    mul_n_d = mod_q;
                    state_d = ST_SQ_REQ;
                end
            end
            ST_SQ_REQ: begin
                state_d = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (answer_ok) begin
                    acc_d = mul_answer;
                    if (scan_bit) begin
                        // Operands must already hold the new acc when
                        // mul_start rises in MUL_REQ.
                        mul_a_d = mul_answer;
                        mul_b_d = base_q;
                        state_d = ST_MUL_REQ;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
            ST_MUL_REQ: begin
                state_d = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: begin
                if (answer_ok) begin
                    acc_d   = mul_answer;
                    state_d = ST_NEXT;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_FINISH;
                end
            end
            ST_NEXT: begin
                if (scan_last) begin
                    result_d = acc_q;
                    state_d  = ST_FINISH;
                end else begin
                    scan_step = 1'b1;
                    mul_a_d   = acc_q;
                    mul_b_d   = acc_q;
                    mul_n_d   = mod_q;
                    state_d   = ST_SQ_REQ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            base_q       <= '0;
            mod_q        <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_n_q      <= '0;
            wait_armed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            mod_q        <= mod_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            err_q        <= err_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_n_q      <= mul_n_d;
            wait_armed_q <= (state_q == ST_SQ_WAIT) || (state_q == ST_MUL_WAIT);
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done      = (state_q == ST_FINISH);
    assign mul_start = (state_q == ST_SQ_REQ) || (state_q == ST_MUL_REQ);
    assign err       = err_q;
    assign result    = result_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_n     = mul_n_q;

endmodule
`default_nettype wire
